hc_nibble_subtractor: RTL and testbench
=======================================

Name: hc_nibble_subtractor

Overview:
Sequential multi-nibble binary subtractor. It is the inverse-direction companion to the team's 4-bit HC_283 adder and is built the same way as a chain of 283s.
- Computes Minuend − Subtrahend one 4-bit nibble per clock, LSB nibble first.
- Each nibble step is the classic 283 trick: A + ~B + carry-in.
- Sits beside the 74-series arithmetic library as a shared, area-cheap subtract unit with a start/done handshake.

Parameters:
NIBBLES, 4, operand width in nibbles; total width W = 4*NIBBLES; legal range 1..16.

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  synchronous, active-high reset
Start  input  1  request pulse; sampled only in IDLE
Minuend  input  W  operand A; captured on the accepted Start
Subtrahend  input  W  operand B; captured on the accepted Start
Busy  output  1  high in RUN and DONE
Done  output  1  one-cycle pulse; result valid
Difference  output  W  A − B modulo 2^W; held until the next accepted Start
Borrow  output  1  1 when A < B (unsigned); equals ~final carry
Zero  output  1  1 when Difference == 0

Behaviour:
- One clock domain. Reset is synchronous and active-high: Rst is sampled on the rising edge of Clk and takes priority over every other input.
- Reset values: state = IDLE; Busy, Done, Borrow, Zero = 0; Difference = 0; internal carry = 1; nibble index = 0.
- States: IDLE, RUN, DONE.
- IDLE → RUN:
  - Happens on an edge where Start = 1.
  - Latches Minuend and Subtrahend into operand shift registers.
  - Sets carry = 1 and index = 0.
- RUN, each edge:
  - sum5 = A_nib + (~B_nib & 4'hF) + carry.
  - The low 4 bits of sum5 are written to nibble[index] of the result accumulator.
  - carry ← sum5[4].
  - index increments.
  - On the edge that processes index = NIBBLES−1:
    - Difference ← full accumulator, including the nibble being written.
    - Borrow ← ~sum5[4].
    - Zero ← (final result == 0).
    - State → DONE.
- DONE: Done = 1 for exactly one cycle, then state → IDLE.
- Latency: with the Start-accepting edge as edge 0, Done is high in the cycle after edge NIBBLES.
- Throughput: one operation per NIBBLES+2 cycles. A Start held high in IDLE right after DONE starts the next operation immediately.
- Start in RUN or DONE is ignored. Operands are not re-captured and no request is queued.
- Difference, Borrow and Zero keep their previous values during RUN. They change only on the RUN→DONE edge and on reset.
- Arithmetic wraps modulo 2^W.
- A == B gives Difference = 0, Borrow = 0, Zero = 1.
- Rst during RUN aborts the operation. The next cycle is IDLE with all outputs at reset values. Partial results are never exposed.
- Operand inputs are don't-care outside the Start-accepting edge.

Optional Feature:
Macro: HC_SUB_SIGNED_OVF_EN.
- Defined:
  - Adds output port Overflow (1 bit), reset 0.
  - Updated on the RUN→DONE edge: Overflow = (A[W-1] != B[W-1]) && (Difference[W-1] != A[W-1]).
  - This is two's-complement overflow.
- Not defined: no Overflow port and no logic for it; all other behaviour is identical.

Decomposition:
- Package hc_sub_pkg:
  - NIBBLE_W = 4.
  - State enum {IDLE, RUN, DONE}, 2 bits.
  - Function clog2 for sizing the index.
- Sub-module hc_nibble_addsub (combinational):
  - Inputs a[3:0], b[3:0], cin, sub.
  - Outputs s[3:0], cout.
  - Computes a + (b ^ {4{sub}}) + cin.
  - Instantiated once with sub = 1; mirrors the HC_283 datapath.

Test Plan (NIBBLES = 4):
- Rst held 2 cycles, then released → Busy = 0, Done = 0, Difference = 0x0000, Borrow = 0, Zero = 0.
- Start with A = 0x1234, B = 0x0234 → Done 4 cycles after the Start-accepting edge; Difference = 0x1000, Borrow = 0, Zero = 0.
- A = 0x0000, B = 0x0001 → Difference = 0xFFFF, Borrow = 1. Repeat with A = 0xFFFF, B = 0xFFFF → Difference = 0x0000, Zero = 1, Borrow = 0.
- Start A = 0x0010, B = 0x0001, then pulse Start again in RUN cycle 2 with A = 0xAAAA → result 0x000F; no second Done follows.
- Start A = 0x5678, B = 0x1111, assert Rst in RUN cycle 2 → IDLE next cycle, all outputs 0, no Done. A following Start gives Difference = 0x4567.
- With HC_SUB_SIGNED_OVF_EN: A = 0x8000, B = 0x0001 → Difference = 0x7FFF, Overflow = 1. A = 0x0005, B = 0x0003 → Overflow = 0.

Source files
------------

// File: rtl/hc_nibble_subtractor_pkg.sv
// Shared types and helpers for the nibble-serial subtractor.
// Optional signed overflow output is enabled with HC_SUB_SIGNED_OVF_EN.
package hc_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so a single-nibble build still has an index bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hc_nibble_subtractor_if.sv
// Start/done request bus of the nibble-serial subtractor.
// Overflow exists only when HC_SUB_SIGNED_OVF_EN is defined.
interface hc_nibble_subtractor_if #(
    parameter int NIBBLES = 4
);
    localparam int W = hc_sub_pkg::NIBBLE_W * NIBBLES;

    logic         Start;
    logic [W-1:0] Minuend;
    logic [W-1:0] Subtrahend;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Difference;
    logic         Borrow;
    logic         Zero;
`ifdef HC_SUB_SIGNED_OVF_EN
    logic         Overflow;

    modport master (output Start, Minuend, Subtrahend,
                    input  Busy, Done, Difference, Borrow, Zero, Overflow);
    modport slave  (input  Start, Minuend, Subtrahend,
                    output Busy, Done, Difference, Borrow, Zero, Overflow);
`else
    modport master (output Start, Minuend, Subtrahend,
                    input  Busy, Done, Difference, Borrow, Zero);
    modport slave  (input  Start, Minuend, Subtrahend,
                    output Busy, Done, Difference, Borrow, Zero);
`endif

endinterface

// File: rtl/hc_nibble_subtractor_addsub.sv
// One HC_283-style nibble slice: a + (b ^ {4{sub}}) + cin, purely combinational.
// No state, no handshake; result settles within the same cycle.
module hc_nibble_addsub
    import hc_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b ^ {NIBBLE_W{sub}}} + {{NIBBLE_W{1'b0}}, cin};
    assign s    = sum[NIBBLE_W-1:0];
    assign cout = sum[NIBBLE_W];

endmodule

// File: rtl/hc_nibble_subtractor.sv
// Nibble-serial A - B, LSB nibble first; Done pulses NIBBLES+1 cycles after the accepted Start.
// Start is honoured only in IDLE; HC_SUB_SIGNED_OVF_EN adds a two's-complement Overflow flag.
module hc_nibble_subtractor
    import hc_sub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    hc_nibble_subtractor_if.slave bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = clog2(NIBBLES);

    state_e             state;
    logic [W-1:0]       aShift;
    logic [W-1:0]       bShift;
    logic [W-1:0]       acc;
    logic [W-1:0]       accNext;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [NIBBLE_W-1:0] nibSum;
    logic               nibCout;
    logic               lastNib;
    logic [W-1:0]       diffReg;
    logic               borrowReg;
    logic               zeroReg;

    hc_nibble_addsub u_addsub (
        .a    (aShift[NIBBLE_W-1:0]),
        .b    (bShift[NIBBLE_W-1:0]),
        .cin  (carry),
        .sub  (1'b1),
        .s    (nibSum),
        .cout (nibCout)
    );

    assign lastNib = (idx == IDX_W'(NIBBLES - 1));

    // The final edge publishes the accumulator including the nibble being written now.
    always_comb begin
        accNext = acc;
        accNext[idx * NIBBLE_W +: NIBBLE_W] = nibSum;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            aShift    <= '0;
            bShift    <= '0;
            acc       <= '0;
            carry     <= 1'b1;
            idx       <= '0;
            diffReg   <= '0;
            borrowReg <= 1'b0;
            zeroReg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        aShift <= bus.Minuend;
                        bShift <= bus.Subtrahend;
                        acc    <= '0;
                        carry  <= 1'b1;
                        idx    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    aShift <= aShift >> NIBBLE_W;
                    bShift <= bShift >> NIBBLE_W;
                    acc    <= accNext;
                    carry  <= nibCout;
                    idx    <= idx + 1'b1;
                    if (lastNib) begin
                        diffReg   <= accNext;
                        borrowReg <= ~nibCout;
                        zeroReg   <= (accNext == '0);
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy       = (state != IDLE);
    assign bus.Done       = (state == DONE);
    assign bus.Difference = diffReg;
    assign bus.Borrow     = borrowReg;
    assign bus.Zero       = zeroReg;

`ifdef HC_SUB_SIGNED_OVF_EN
    // Operand signs are kept aside because the shift registers lose the top bits.
    logic aSign;
    logic bSign;
    logic ovfReg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            aSign  <= 1'b0;
            bSign  <= 1'b0;
            ovfReg <= 1'b0;
        end else begin
            if (state == IDLE && bus.Start) begin
                aSign <= bus.Minuend[W-1];
                bSign <= bus.Subtrahend[W-1];
            end
            if (state == RUN && lastNib) begin
                ovfReg <= (aSign != bSign) && (accNext[W-1] != aSign);
            end
        end
    end

    assign bus.Overflow = ovfReg;
`endif

endmodule

// File: tb/tb_hc_nibble_subtractor.sv
// Directed bench for hc_nibble_subtractor with NIBBLES = 4; expected results queued at issue time.
module tb_hc_nibble_subtractor;

    localparam int NIBBLES = 4;

    typedef struct {
        logic [15:0] d;
        logic        bw;
        logic        z;
        logic        ov;
        int          cyc;
    } exp_t;

    logic Clk;
    logic Rst;
    int   cyc;
    int   tests;
    int   fails;
    exp_t q[$];
    logic [15:0] lastDiff;
    logic        lastBw;
    logic        lastZ;

    hc_nibble_subtractor_if #(.NIBBLES(NIBBLES)) bus ();

    hc_nibble_subtractor #(.NIBBLES(NIBBLES)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits for IDLE, drives one Start cycle and optionally queues the expected result.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d,
                         input logic bw, input logic z, input logic ov, input bit push);
        exp_t e;
        int   n;
        n = 0;
        while (bus.Busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (bus.Busy) chk("idle_wait_timeout", 32'd1, 32'd0);
        bus.Start      = 1'b1;
        bus.Minuend    = a;
        bus.Subtrahend = b;
        if (push) begin
            e.d = d; e.bw = bw; e.z = z; e.ov = ov;
            e.cyc = cyc + 1 + NIBBLES;
            q.push_back(e);
        end
        @(negedge Clk);
        bus.Start      = 1'b0;
        bus.Minuend    = 16'hDEAD;
        bus.Subtrahend = 16'hBEEF;
    endtask

    // Monitor: pops on Done, checks that results hold steady while busy.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (!Rst) begin
                if (bus.Done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("done_cycle", cyc, e.cyc);
                        chk("difference", {16'd0, bus.Difference}, {16'd0, e.d});
                        chk("borrow", {31'd0, bus.Borrow}, {31'd0, e.bw});
                        chk("zero", {31'd0, bus.Zero}, {31'd0, e.z});
`ifdef HC_SUB_SIGNED_OVF_EN
                        chk("overflow", {31'd0, bus.Overflow}, {31'd0, e.ov});
`endif
                        lastDiff = e.d;
                        lastBw   = e.bw;
                        lastZ    = e.z;
                    end
                end else if (bus.Busy) begin
                    chk("hold_difference", {16'd0, bus.Difference}, {16'd0, lastDiff});
                    chk("hold_flags", {30'd0, bus.Borrow, bus.Zero}, {30'd0, lastBw, lastZ});
                end
            end
        end
    end

    initial begin
        int n;
        tests = 0;
        fails = 0;
        lastDiff = '0; lastBw = 1'b0; lastZ = 1'b0;
        Rst = 1'b1;
        bus.Start = 1'b0;
        bus.Minuend = '0;
        bus.Subtrahend = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_done", {31'd0, bus.Done}, 32'd0);
        chk("rst_difference", {16'd0, bus.Difference}, 32'd0);
        chk("rst_borrow", {31'd0, bus.Borrow}, 32'd0);
        chk("rst_zero", {31'd0, bus.Zero}, 32'd0);
`ifdef HC_SUB_SIGNED_OVF_EN
        chk("rst_overflow", {31'd0, bus.Overflow}, 32'd0);
`endif
        @(negedge Clk);

        issue(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Start pulsed again mid-operation must be ignored.
        issue(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.Start = 1'b1;
        bus.Minuend = 16'hAAAA;
        @(negedge Clk);
        bus.Start = 1'b0;

        // Reset during RUN aborts with no Done and clean outputs.
        issue(16'h5678, 16'h1111, 16'h4567, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        lastDiff = '0; lastBw = 1'b0; lastZ = 1'b0;
        chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
        chk("abort_done", {31'd0, bus.Done}, 32'd0);
        chk("abort_outputs", {14'd0, bus.Difference, bus.Borrow, bus.Zero}, 32'd0);
        issue(16'h5678, 16'h1111, 16'h4567, 1'b0, 1'b0, 1'b0, 1'b1);

        issue(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(16'h0003, 16'h8000, 16'h8003, 1'b1, 1'b0, 1'b1, 1'b1);
        issue(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        repeat (2 * NIBBLES) @(negedge Clk);
        chk("queue_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
